// File: rtl/count_pulse_gen_if.sv
// Push-button bundle: raw button level in, debounced level and count pulse out.
interface count_pulse_gen_if;
    logic button;
    logic count;
    logic held;

    modport master (output button, input count, held);
    modport slave  (input button, output count, held);
endinterface

// File: rtl/count_pulse_gen.sv
// Debounced push-button to single-cycle count pulse, with optional auto-repeat
// while the button stays held.
module count_pulse_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 16,
    parameter int unsigned REPEAT_PERIOD   = 8,
    parameter bit          REPEAT_ENABLE   = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    count_pulse_gen_if.slave  bus
);

    localparam int unsigned TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam int unsigned DBW  = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0]  DELAY_LAST = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0]  PER_LAST   = TW'(REPEAT_PERIOD - 1);
    localparam logic [TW-1:0]  TIMER_SAT  = TW'(TMAX);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HOLD_WAIT = 2'd1,
        REPEAT    = 2'd2
    } state_e;

    logic [1:0]     sync_q;
    logic           held_q, held_d;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic [TW-1:0]  timer_q, timer_d;
    state_e         state_q, state_d;
    logic           count_q, count_d;
    logic           rise, fall;

    // NOTE: every register here is a flop with a synchronous clear, so all of
    // them (synchronizer included) share one reset branch and use <= only.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_q   <= '0;
            held_q   <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            sync_q   <= {sync_q[0], bus.button};
            held_q   <= held_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    // NOTE: defaults first so no path through the comb blocks infers a latch.
    always_comb begin
        held_d   = held_q;
        db_cnt_d = '0;
        if (sync_q[1] != held_q) begin
            if (db_cnt_q == DB_LAST) begin
                held_d = ~held_q;
            end else begin
                db_cnt_d = db_cnt_q + DBW'(1);
            end
        end
    end

    assign rise = held_d & ~held_q;
    assign fall = ~held_d & held_q;

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            count_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            count_q <= count_d;
        end
    end

    // Next-state logic; release is checked before timer expiry so it wins.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                if (rise) state_d = HOLD_WAIT;
            end
            HOLD_WAIT: begin
                if (fall) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (REPEAT_ENABLE && timer_q == DELAY_LAST) begin
                    state_d = REPEAT;
                    timer_d = '0;
                end else if (timer_q != TIMER_SAT) begin
                    timer_d = timer_q + TW'(1);
                end
            end
            REPEAT: begin
                if (fall) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (timer_q == PER_LAST) begin
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        count_d = 1'b0;
        unique case (state_q)
            IDLE:      count_d = rise;
            HOLD_WAIT: count_d = ~fall & REPEAT_ENABLE & (timer_q == DELAY_LAST);
            REPEAT:    count_d = ~fall & (timer_q == PER_LAST);
            default:   count_d = 1'b0;
        endcase
    end

    assign bus.count = count_q;
    assign bus.held  = held_q;

endmodule

// File: tb/tb_count_pulse_gen.sv
// Directed bench: two instances (auto-repeat on/off) driven with the same
// button/reset patterns; per-edge outputs are logged as bit masks and compared.
module tb_count_pulse_gen;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    count_pulse_gen_if bus0 ();
    count_pulse_gen_if bus1 ();

    count_pulse_gen #(.REPEAT_ENABLE(1'b1)) dut0 (.clock(clock), .reset(reset), .bus(bus0.slave));
    count_pulse_gen #(.REPEAT_ENABLE(1'b0)) dut1 (.clock(clock), .reset(reset), .bus(bus1.slave));

    int errors = 0;
    int checks = 0;

    logic [63:0] cnt0_m, cnt1_m, held0_m, held1_m;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] range_mask(input int lo, input int hi);
        logic [63:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] bit_at(input int b);
        logic [63:0] m = '0;
        m[b] = 1'b1;
        return m;
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        bus0.button = 1'b0;
        bus1.button = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clock);
            #1;
            check("rst_count0", {63'd0, bus0.count}, 64'd0);
            check("rst_held0",  {63'd0, bus0.held},  64'd0);
            check("rst_count1", {63'd0, bus1.count}, 64'd0);
            check("rst_held1",  {63'd0, bus1.held},  64'd0);
        end
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(posedge clock);
    endtask

    // Edge e (1-based) samples button=(e<=hi); reset is low only at edge rst_e.
    task automatic apply(input int hi, input int total, input int rst_e);
        cnt0_m = '0; cnt1_m = '0; held0_m = '0; held1_m = '0;
        for (int e = 1; e <= total; e++) begin
            @(negedge clock);
            bus0.button = (e <= hi);
            bus1.button = (e <= hi);
            reset       = (e == rst_e) ? 1'b0 : 1'b1;
            @(posedge clock);
            #1;
            cnt0_m[e]  = bus0.count;
            cnt1_m[e]  = bus1.count;
            held0_m[e] = bus0.held;
            held1_m[e] = bus1.held;
        end
        @(negedge clock);
        reset = 1'b1;
        bus0.button = 1'b0;
        bus1.button = 1'b0;
        check("no_double0", cnt0_m & (cnt0_m << 1), 64'd0);
        check("no_double1", cnt1_m & (cnt1_m << 1), 64'd0);
    endtask

    initial begin
        bus0.button = 1'b0;
        bus1.button = 1'b0;

        // Idle after reset
        do_reset();
        apply(0, 10, 0);
        check("idle_count0", cnt0_m, 64'd0);
        check("idle_held0",  held0_m, 64'd0);

        // Three-sample glitch is rejected
        do_reset();
        apply(3, 20, 0);
        check("glitch_count0", cnt0_m, 64'd0);
        check("glitch_held0",  held0_m, 64'd0);
        check("glitch_count1", cnt1_m, 64'd0);

        // Short press: one pulse at E6, held E6..E15
        do_reset();
        apply(10, 25, 0);
        check("short_count0", cnt0_m, bit_at(6));
        check("short_held0",  held0_m, range_mask(6, 15));
        check("short_count1", cnt1_m, bit_at(6));
        check("short_held1",  held1_m, range_mask(6, 15));

        // Long press: repeats at E22/E30/E38, E46 expiry lost to release
        do_reset();
        apply(40, 60, 0);
        check("long_count0", cnt0_m, bit_at(6) | bit_at(22) | bit_at(30) | bit_at(38));
        check("long_held0",  held0_m, range_mask(6, 45));
        check("long_e46_count0", {63'd0, cnt0_m[46]}, 64'd0);
        check("long_count1", cnt1_m, bit_at(6));
        check("long_held1",  held1_m, range_mask(6, 45));

        // Reset pulse at E25 while held: restart as a new press, pulse at E31
        do_reset();
        apply(40, 45, 25);
        check("mid_rst_count0", cnt0_m, bit_at(6) | bit_at(22) | bit_at(31));
        check("mid_rst_held0",  held0_m, range_mask(6, 24) | range_mask(31, 45));
        check("mid_rst_count1", cnt1_m, bit_at(6) | bit_at(31));
        check("mid_rst_held1",  held1_m, range_mask(6, 24) | range_mask(31, 45));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
